// File: rtl/efc_token_scheduler.sv
// efc_token_scheduler
//   Maximal-step firing scheduler for a three-FSM token net. Each step
//   evaluates the enabled transitions, pulses their strobes for one cycle,
//   then checks that the FSMs report the expected post-step marking.
//   The hidden FSM2 places p3/p5 are shadowed internally as pend3/pend5.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   run               level enable for issuing firing steps
//   choice_sel        t0/t1 choice when CHOICE_MODE=1 (0 -> t0, 1 -> t1)
//   f1_p*/f2_p*/f3_p* observed place indicators of FSM1/FSM2/FSM3
//   t0_ .. t6_        one-cycle transition fire strobes
//   loop_count        completed, checked t6 firings (wraps)
//   busy              high in EVAL/FIRE/CHECK
//   err_marking       sticky post-step marking mismatch
//   err_deadlock      sticky watchdog expiry
module efc_token_scheduler #(
  parameter int unsigned CHOICE_MODE = 0,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        choice_sel,
  input  logic        f1_p0,
  input  logic        f1_p2,
  input  logic        f1_p4,
  input  logic        f1_p6,
  input  logic        f2_p0,
  input  logic        f2_p7,
  input  logic        f3_p1,
  input  logic        f3_p2,
  input  logic        f3_p4,
  input  logic        f3_p6,
  output logic        t0_,
  output logic        t1_,
  output logic        t2_,
  output logic        t3_,
  output logic        t4_,
  output logic        t5_,
  output logic        t6_,
  output logic [15:0] loop_count,
  output logic        busy,
  output logic        err_marking,
  output logic        err_deadlock
);

  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_FIRE, S_CHECK, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [6:0]    strobe_q, strobe_d;
  logic [6:0]    fired_q, fired_d;
  logic [9:0]    exp_q, exp_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          alt_q, alt_d;
  logic          pend3_q, pend3_d, pend5_q, pend5_d;
  logic [15:0]   loop_q, loop_d;
  logic          errm_q, errm_d, errd_q, errd_d;

  logic          en01, en2, en3, en4, en5, en6, pick_t1;
  logic [6:0]    fire;
  logic [9:0]    obs, exp_m;
  logic          groups_ok;

  // Observed marking, same bit order as the registered expectation.
  assign obs = {f3_p6, f3_p4, f3_p2, f3_p1, f2_p7, f2_p0, f1_p6, f1_p4, f1_p2, f1_p0};

  assign en01 = f1_p0 & f2_p0 & f3_p1;
  assign en2  = f1_p2 & f3_p2;
  assign en4  = f1_p4 & f3_p4;
  assign en3  = pend3_q;
  assign en5  = pend5_q;
  assign en6  = f1_p6 & f2_p7 & f3_p6 & ~pend3_q & ~pend5_q;

  assign pick_t1 = (CHOICE_MODE == 1) ? choice_sel : alt_q;
  assign fire = {en6, en5, en4, en3, en2, en01 & pick_t1, en01 & ~pick_t1};

  // Post-step marking: tokens consumed by fired inputs, produced on outputs.
  always_comb begin
    exp_m[0] = (f1_p0 & ~(fire[0] | fire[1])) | fire[6];
    exp_m[1] = (f1_p2 & ~fire[2]) | fire[0];
    exp_m[2] = (f1_p4 & ~fire[4]) | fire[1];
    exp_m[3] = (f1_p6 & ~fire[6]) | fire[2] | fire[4];
    exp_m[4] = (f2_p0 & ~(fire[0] | fire[1])) | fire[6];
    exp_m[5] = (f2_p7 & ~fire[6]) | fire[3] | fire[5];
    exp_m[6] = (f3_p1 & ~(fire[0] | fire[1])) | fire[6];
    exp_m[7] = (f3_p2 & ~fire[2]) | fire[0];
    exp_m[8] = (f3_p4 & ~fire[4]) | fire[1];
    exp_m[9] = (f3_p6 & ~fire[6]) | fire[2] | fire[4];
  end

  // FSM2 is one-hot only when its hidden places (pend3/pend5) are included.
  assign groups_ok = $onehot({f1_p0, f1_p2, f1_p4, f1_p6}) &&
                     $onehot({f2_p0, f2_p7, pend3_q, pend5_q}) &&
                     $onehot({f3_p1, f3_p2, f3_p4, f3_p6});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      strobe_q <= '0;
      fired_q  <= '0;
      exp_q    <= '0;
      wdog_q   <= '0;
      alt_q    <= 1'b0;
      pend3_q  <= 1'b0;
      pend5_q  <= 1'b0;
      loop_q   <= '0;
      errm_q   <= 1'b0;
      errd_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
      fired_q  <= fired_d;
      exp_q    <= exp_d;
      wdog_q   <= wdog_d;
      alt_q    <= alt_d;
      pend3_q  <= pend3_d;
      pend5_q  <= pend5_d;
      loop_q   <= loop_d;
      errm_q   <= errm_d;
      errd_q   <= errd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    strobe_d = '0;
    fired_d  = fired_q;
    exp_d    = exp_q;
    wdog_d   = wdog_q;
    alt_d    = alt_q;
    pend3_d  = pend3_q;
    pend5_d  = pend5_q;
    loop_d   = loop_q;
    errm_d   = errm_q;
    errd_d   = errd_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (|fire) begin
          strobe_d = fire;
          fired_d  = fire;
          exp_d    = exp_m;
          wdog_d   = '0;
          if (en01 && CHOICE_MODE == 0) alt_d = ~alt_q;
          state_d  = S_FIRE;
        end else if (wdog_q == WDOG_LAST) begin
          errd_d  = 1'b1;
          state_d = S_ERR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_FIRE: begin
        // Hidden FSM2 places move on the same edge as the FSMs themselves.
        pend3_d = (pend3_q | fired_q[0]) & ~fired_q[3];
        pend5_d = (pend5_q | fired_q[1]) & ~fired_q[5];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (obs != exp_q || !groups_ok) begin
          errm_d  = 1'b1;
          state_d = S_ERR;
        end else begin
          if (fired_q[6]) loop_d = loop_q + 16'd1;
          state_d = run ? S_EVAL : S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign {t6_, t5_, t4_, t3_, t2_, t1_, t0_} = strobe_q;
  assign loop_count   = loop_q;
  assign busy         = (state_q == S_EVAL) || (state_q == S_FIRE) || (state_q == S_CHECK);
  assign err_marking  = errm_q;
  assign err_deadlock = errd_q;

endmodule
